// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the datapath and the pipeline hazard controller.
// master = datapath side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic [REG_W-1:0] rs1_D;
    logic [REG_W-1:0] rs2_D;
    logic [REG_W-1:0] rd_E;
    logic             memread_E;
    logic             pcsrc_E;
    logic             memreq_M;
    logic             mem_ready;
    logic             stall_PC;
    logic             stall_D;
    logic             stall_E;
    logic             stall_M;
    logic             flush_D;
    logic             flush_E;
    logic             flush_W;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs1_D, rs2_D, rd_E, memread_E, pcsrc_E, memreq_M, mem_ready,
        input  stall_PC, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
        input  mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1_D, rs2_D, rd_E, memread_E, pcsrc_E, memreq_M, mem_ready,
        output stall_PC, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
        output mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, MEM-stage wait with timeout.
// Optional saturating stall/flush performance counters built when HAZ_PERF_EN is defined.
module hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);
    // state    | meaning
    // RUN      | normal flow; load-use and branch hazards evaluated
    // MEM_WAIT | pipe frozen while data memory holds off the MEM access
    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    localparam int CW = $clog2(TIMEOUT) + 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_err_q, mem_err_d;
    logic          lu, mw;
    logic          stall_pc, stall_d, stall_e, stall_m;
    logic          flush_d, flush_e, flush_w;

    assign lu = hz.memread_E && (hz.rd_E != REG_W'(0)) &&
                ((hz.rd_E == hz.rs1_D) || (hz.rd_E == hz.rs2_D));
    assign mw = hz.memreq_M && !hz.mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q;
        stall_pc  = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_w   = 1'b0;
        case (state_q)
            RUN: begin
                if (mw) begin
                    {stall_pc, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
                    state_d = MEM_WAIT;
                    cnt_d   = CW'(1);
                end else if (hz.pcsrc_E) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (lu) begin
                    stall_pc = 1'b1;
                    stall_d  = 1'b1;
                    flush_e  = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ready) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    {stall_pc, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        mem_err_d = 1'b1;
                        state_d   = RUN;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
        // Mealy outputs would otherwise react to live inputs while reset holds the FSM.
        if (reset) begin
            {stall_pc, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w} = 7'b0;
        end
    end

    assign hz.stall_PC = stall_pc;
    assign hz.stall_D  = stall_d;
    assign hz.stall_E  = stall_e;
    assign hz.stall_M  = stall_m;
    assign hz.flush_D  = flush_d;
    assign hz.flush_E  = flush_e;
    assign hz.flush_W  = flush_w;
    assign hz.mem_err  = mem_err_q;

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_pc && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_d && !(&flush_cnt_q))  flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = {CNT_W{1'b0}};
    assign hz.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch, mem wait, timeout, reset, counters.
// Counter expectations follow HAZ_PERF_EN the same way the design does.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   es          = 0;
    int   ef          = 0;

    hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) hz ();

    hazard_ctrl #(.REG_W(5), .TIMEOUT(16), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    always #5 clk = ~clk;

    logic [6:0] outs;
    assign outs = {hz.stall_PC, hz.stall_D, hz.stall_E, hz.stall_M,
                   hz.flush_D, hz.flush_E, hz.flush_W};

    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_LU   = 7'b1100010;
    localparam logic [6:0] O_BR   = 7'b0000110;
    localparam logic [6:0] O_MW   = 7'b1111001;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
`ifdef HAZ_PERF_EN
        chk({tag, "_stall_cnt"}, hz.stall_cnt, 32'(es));
        chk({tag, "_flush_cnt"}, hz.flush_cnt, 32'(ef));
`else
        chk({tag, "_stall_cnt"}, hz.stall_cnt, 32'd0);
        chk({tag, "_flush_cnt"}, hz.flush_cnt, 32'd0);
`endif
    endtask

    // Check the Mealy outputs for the inputs already applied, then advance one clock.
    task automatic step(input string tag, input logic [6:0] exp_o);
        #1;
        chk(tag, 32'(outs), 32'(exp_o));
        if (exp_o[6]) es++;
        if (exp_o[2]) ef++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz.rs1_D = 5'd0; hz.rs2_D = 5'd0; hz.rd_E = 5'd0;
        hz.memread_E = 1'b0; hz.pcsrc_E = 1'b0;
        hz.memreq_M = 1'b0; hz.mem_ready = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", 32'(outs), 32'(O_NONE));
        chk("rst_err", 32'(hz.mem_err), 32'd0);
        chk_cnt("rst");
        reset = 1'b0;
        @(posedge clk); #1;

        // load-use on rs2, then load leaves E
        hz.memread_E = 1'b1; hz.rd_E = 5'd5; hz.rs1_D = 5'd3; hz.rs2_D = 5'd5;
        step("lu_rs2", O_LU);
        hz.memread_E = 1'b0; hz.rd_E = 5'd9;
        step("lu_clear", O_NONE);
        hz.memread_E = 1'b1; hz.rd_E = 5'd0; hz.rs1_D = 5'd0; hz.rs2_D = 5'd0;
        step("lu_x0", O_NONE);
        hz.rd_E = 5'd7; hz.rs1_D = 5'd7; hz.rs2_D = 5'd1;
        step("lu_rs1", O_LU);
        hz.memread_E = 1'b0;
        step("no_load", O_NONE);
        chk_cnt("after_lu");

        // branch wins over load-use
        hz.memread_E = 1'b1; hz.pcsrc_E = 1'b1;
        step("br_lu", O_BR);
        hz.memread_E = 1'b0;
        step("br_only", O_BR);
        idle_inputs();
        step("idle", O_NONE);

        // mem wait: three not-ready cycles, branch ignored while frozen
        hz.memreq_M = 1'b1; hz.mem_ready = 1'b0;
        step("mw_entry", O_MW);
        hz.pcsrc_E = 1'b1;
        step("mw_w1_br", O_MW);
        hz.pcsrc_E = 1'b0; hz.memread_E = 1'b1; hz.rd_E = 5'd4; hz.rs1_D = 5'd4;
        step("mw_w2_lu", O_MW);
        hz.mem_ready = 1'b1;
        step("mw_ready", O_NONE);
        hz.memreq_M = 1'b0; hz.mem_ready = 1'b0;
        step("mw_back_run", O_LU);
        chk("mw_err", 32'(hz.mem_err), 32'd0);
        chk_cnt("after_mw");
        idle_inputs();

        // ready arrives on the last allowed wait cycle: no error
        hz.memreq_M = 1'b1;
        for (int i = 0; i < 15; i++) step("edge_wait", O_MW);
        hz.mem_ready = 1'b1;
        step("edge_ready", O_NONE);
        chk("edge_err", 32'(hz.mem_err), 32'd0);
        idle_inputs();

        // timeout: 16 stall cycles, error sticky afterwards
        hz.memreq_M = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("to_err_pre", 32'(hz.mem_err), 32'd0);
            step("to_wait", O_MW);
        end
        hz.memreq_M = 1'b0;
        step("to_resume", O_NONE);
        chk("to_err", 32'(hz.mem_err), 32'd1);
        hz.pcsrc_E = 1'b1;
        step("to_br", O_BR);
        hz.pcsrc_E = 1'b0;
        step("to_idle", O_NONE);
        chk("to_err_sticky", 32'(hz.mem_err), 32'd1);
        chk_cnt("after_to");

        // reset in the third MEM_WAIT cycle
        hz.memreq_M = 1'b1;
        step("rw_entry", O_MW);
        step("rw_w1", O_MW);
        #1;
        chk("rw_w2", 32'(outs), 32'(O_MW));
        reset = 1'b1;
        es = 0; ef = 0;
        #1;
        chk("rw_rst_outs", 32'(outs), 32'(O_NONE));
        chk("rw_rst_err", 32'(hz.mem_err), 32'd0);
        chk_cnt("rw_rst");
        @(posedge clk); #1;
        chk("rw_hold_outs", 32'(outs), 32'(O_NONE));
        hz.memreq_M = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        hz.memread_E = 1'b1; hz.rd_E = 5'd12; hz.rs2_D = 5'd12;
        step("rw_run_lu", O_LU);
        chk("rw_err_after", 32'(hz.mem_err), 32'd0);
        chk_cnt("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1);
    end
endmodule
